// File: rtl/sudoku_pkg.sv
// Shared constants, types and the group-to-cell table for the 4x4 Sudoku checker.
package sudoku_pkg;

  localparam int unsigned CELL_W  = 3;
  localparam int unsigned NCELLS  = 16;
  localparam int unsigned NGROUPS = 12;
  localparam int unsigned BOARD_W = CELL_W * NCELLS;

  typedef logic [CELL_W-1:0] cell_t;
  typedef logic [3:0]        idx_t;

  localparam cell_t CELL_EMPTY = 3'd0;
  localparam cell_t CELL_MAX   = 3'd4;

  typedef enum logic [2:0] {
    StIdle,
    StSnap,
    StScanCells,
    StScanGroups,
    StDone
  } state_e;

  // Groups 0-3 are rows, 4-7 columns, 8-11 2x2 boxes; matches conflict mask bit order.
  localparam idx_t GROUP_TBL [NGROUPS][4] = '{
    '{4'd0,  4'd1,  4'd2,  4'd3},
    '{4'd4,  4'd5,  4'd6,  4'd7},
    '{4'd8,  4'd9,  4'd10, 4'd11},
    '{4'd12, 4'd13, 4'd14, 4'd15},
    '{4'd0,  4'd4,  4'd8,  4'd12},
    '{4'd1,  4'd5,  4'd9,  4'd13},
    '{4'd2,  4'd6,  4'd10, 4'd14},
    '{4'd3,  4'd7,  4'd11, 4'd15},
    '{4'd0,  4'd1,  4'd4,  4'd5},
    '{4'd2,  4'd3,  4'd6,  4'd7},
    '{4'd8,  4'd9,  4'd12, 4'd13},
    '{4'd10, 4'd11, 4'd14, 4'd15}
  };

  function automatic cell_t cell_at(input logic [BOARD_W-1:0] board, input idx_t idx);
    return board[CELL_W*idx +: CELL_W];
  endfunction

  function automatic logic is_legal(input cell_t v);
    return (v != CELL_EMPTY) && (v <= CELL_MAX);
  endfunction

endpackage

// File: rtl/sudoku_group_dup.sv
// Combinational duplicate detector for one four-cell Sudoku group.
module sudoku_group_dup
  import sudoku_pkg::*;
(
  input  logic [CELL_W-1:0] cell0,
  input  logic [CELL_W-1:0] cell1,
  input  logic [CELL_W-1:0] cell2,
  input  logic [CELL_W-1:0] cell3,
  output logic              dup
);

  // Six pairwise compares; a pair only counts when the value is a legal digit.
  always_comb begin
    dup = 1'b0;
    if (is_legal(cell0) && (cell0 == cell1)) dup = 1'b1;
    if (is_legal(cell0) && (cell0 == cell2)) dup = 1'b1;
    if (is_legal(cell0) && (cell0 == cell3)) dup = 1'b1;
    if (is_legal(cell1) && (cell1 == cell2)) dup = 1'b1;
    if (is_legal(cell1) && (cell1 == cell3)) dup = 1'b1;
    if (is_legal(cell2) && (cell2 == cell3)) dup = 1'b1;
  end

endmodule

// File: rtl/sudoku_board_checker.sv
// Snapshots a 4x4 Sudoku board on start and scans cells then groups sequentially.
module sudoku_board_checker
  import sudoku_pkg::*;
(
  input  logic                  in_clka,
  input  logic                  in_restart_n,
  input  logic                  in_start,
  input  logic [BOARD_W-1:0]    in_user_board,
  input  logic [BOARD_W-1:0]    in_real_board,
  input  logic [NCELLS-1:0]     in_fill_flag,
  output logic                  out_busy,
  output logic                  out_done,
  output logic                  out_solved,
  output logic [NCELLS-1:0]     out_mismatch_mask,
  output logic [NGROUPS-1:0]    out_conflict_mask,
  output logic [4:0]            out_empty_count
);

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [BOARD_W-1:0]   user_q, user_d, sol_q, sol_d;
  logic [NCELLS-1:0]    fill_q, fill_d;
  logic [NCELLS-1:0]    mism_q, mism_d;
  logic [NGROUPS-1:0]   conf_q, conf_d;
  logic [4:0]           empty_q, empty_d;
  logic                 busy_q, busy_d, done_q, done_d, solved_q, solved_d;
  logic [NCELLS-1:0]    res_mism_q, res_mism_d;
  logic [NGROUPS-1:0]   res_conf_q, res_conf_d;
  logic [4:0]           res_empty_q, res_empty_d;

  cell_t                cur_cell, sol_cell;
  idx_t                 grp;
  logic                 grp_dup;

  // Cell under scan, and a group index clamped into the table range.
  always_comb begin
    cur_cell = cell_at(user_q, cnt_q);
    sol_cell = cell_at(sol_q, cnt_q);
    grp      = (cnt_q < 4'(NGROUPS)) ? cnt_q : 4'd0;
  end

  sudoku_group_dup u_group_dup (
    .cell0 (cell_at(user_q, GROUP_TBL[grp][0])),
    .cell1 (cell_at(user_q, GROUP_TBL[grp][1])),
    .cell2 (cell_at(user_q, GROUP_TBL[grp][2])),
    .cell3 (cell_at(user_q, GROUP_TBL[grp][3])),
    .dup   (grp_dup)
  );

  // Next-state, accumulator and result logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    user_d      = user_q;
    sol_d       = sol_q;
    fill_d      = fill_q;
    mism_d      = mism_q;
    conf_d      = conf_q;
    empty_d     = empty_q;
    done_d      = 1'b0;
    solved_d    = solved_q;
    res_mism_d  = res_mism_q;
    res_conf_d  = res_conf_q;
    res_empty_d = res_empty_q;

    unique case (state_q)
      StIdle: begin
        if (in_start) state_d = StSnap;
      end
      StSnap: begin
        user_d  = in_user_board;
        sol_d   = in_real_board;
        fill_d  = in_fill_flag;
        mism_d  = '0;
        conf_d  = '0;
        empty_d = '0;
        cnt_d   = '0;
        state_d = StScanCells;
      end
      StScanCells: begin
        if (cur_cell == CELL_EMPTY) begin
          empty_d = empty_q + 5'd1;
        end else if (cur_cell > CELL_MAX) begin
          mism_d[cnt_q] = 1'b1;
        end else begin
          mism_d[cnt_q] = !fill_q[cnt_q] && (cur_cell != sol_cell);
        end
        if (cnt_q == 4'(NCELLS - 1)) begin
          cnt_d   = '0;
          state_d = StScanGroups;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StScanGroups: begin
        conf_d[cnt_q] = grp_dup;
        if (cnt_q == 4'(NGROUPS - 1)) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDone: begin
        res_mism_d  = mism_q;
        res_conf_d  = conf_q;
        res_empty_d = empty_q;
        solved_d    = (empty_q == 5'd0) && (mism_q == '0) && (conf_q == '0);
        done_d      = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Busy is registered from the next state so it covers the scan and done cycles.
    busy_d = (state_d == StScanCells) || (state_d == StScanGroups) || (state_d == StDone);
  end

  // State and datapath registers; reset aborts any scan in flight.
  always_ff @(posedge in_clka or negedge in_restart_n) begin
    if (!in_restart_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      user_q      <= '0;
      sol_q       <= '0;
      fill_q      <= '0;
      mism_q      <= '0;
      conf_q      <= '0;
      empty_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      solved_q    <= 1'b0;
      res_mism_q  <= '0;
      res_conf_q  <= '0;
      res_empty_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      user_q      <= user_d;
      sol_q       <= sol_d;
      fill_q      <= fill_d;
      mism_q      <= mism_d;
      conf_q      <= conf_d;
      empty_q     <= empty_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      solved_q    <= solved_d;
      res_mism_q  <= res_mism_d;
      res_conf_q  <= res_conf_d;
      res_empty_q <= res_empty_d;
    end
  end

  assign out_busy          = busy_q;
  assign out_done          = done_q;
  assign out_solved        = solved_q;
  assign out_mismatch_mask = res_mism_q;
  assign out_conflict_mask = res_conf_q;
  assign out_empty_count   = res_empty_q;

endmodule

// File: doc/sudoku_board_checker.md
Name: sudoku_board_checker

Overview:
Downstream consumer of the 4x4 Sudoku game top level. It takes the user board, real board and fill flags that the top level produces, snapshots them on a start pulse, and scans them sequentially. It reports per-cell mismatches, per-group rule conflicts, empty-cell count and a registered solved verdict. These results feed the display/score logic and the out_solved path.

Parameters:
CELL_W, 3, bits per cell value; 0 = empty, 1-4 = legal, 5-7 = illegal.
NCELLS, 16, cells per board; fixed 4x4; index i = 4*row + col.
NGROUPS, 12, uniqueness groups: 4 rows, 4 cols, 4 2x2 boxes.

Ports:
in_clka  input  1  single system clock; all state changes on rising edge.
in_restart_n  input  1  asynchronous, active-low reset.
in_start  input  1  one-cycle request to check the current boards.
in_user_board  input  48  user cells packed; cell i at [3*i +: 3].
in_real_board  input  48  solution cells, same packing.
in_fill_flag  input  16  bit i = 1 means cell i is a fixed clue; it is exempt from mismatch checking.
out_busy  output  1  scan in progress.
out_done  output  1  one-cycle pulse when results are valid.
out_solved  output  1  board complete and correct.
out_mismatch_mask  output  16  bit i = cell i is wrong.
out_conflict_mask  output  12  [3:0] rows, [7:4] cols, [11:8] boxes; bit = duplicate in that group.
out_empty_count  output  5  number of zero cells, 0..16.

Behaviour:
- Reset (async, active-low): state IDLE, all outputs and internal registers 0. Reset mid-scan aborts the scan; no done pulse is produced.
- States:
  - IDLE -> SNAP on in_start.
  - SNAP (1 cycle): copy both boards and the fill flags into local registers; clear the accumulators. Later input changes are ignored until the next start.
  - SCAN_CELLS: 16 cycles, cell counter 0..15, one cell per cycle.
  - SCAN_GROUPS: 12 cycles, group counter 0..11, one group per cycle.
  - DONE (1 cycle) -> IDLE.
- Latency: in_start sampled high at edge T0. out_busy is high after edges T0+1 through T0+29. out_done is high only after edge T0+30, with results valid in the same cycle.
- in_start while busy or in DONE: ignored, no queueing.
- Cell rule, per cell:
  - Value 0: increments empty_count.
  - Value 5-7: sets the mismatch bit regardless of in_fill_flag.
  - Otherwise: mismatch bit = !fill_flag[i] && (user != real).
- Group rule:
  - Group g gathers 4 cells: row r gives {4r..4r+3}; col c gives {c, c+4, c+8, c+12}; box b gives rows 2*(b/2)..+1 x cols 2*(b%2)..+1.
  - Conflict = any two of the 4 cells with equal values in 1..4. Zeros and illegal values never conflict.
- out_solved = (empty_count == 0) && (mismatch_mask == 0) && (conflict_mask == 0). It is computed in DONE.
- Result outputs update only in DONE and hold until the next DONE or reset. They are not cleared when a new scan starts.
- empty_count saturates by construction at 16 (5 bits); no wrap.

Decomposition:
- Package sudoku_pkg:
  - CELL_W, NCELLS, NGROUPS, CELL_EMPTY = 0, CELL_MAX = 4.
  - State enum {IDLE, SNAP, SCAN_CELLS, SCAN_GROUPS, DONE}.
  - Constant group-to-cell index table (12 x 4 indices).
- Sub-module sudoku_group_dup: combinational; takes four CELL_W values and returns a 1-bit duplicate flag using 6 pairwise compares qualified by 1..4. Instantiated once and time-multiplexed by the group counter.

Test Plan:
- Reset: hold in_restart_n low while in_start = 1. Required: all outputs 0 and out_busy 0. Deassert reset: still idle with no done pulse.
- Solved board: user = real = rows 1234/3412/2143/4321, fill = 16'h0000, pulse start. Required: busy for 29 cycles, done at T0+30, solved = 1, mismatch = 16'h0000, conflict = 12'h000, empty = 0.
- Single empty: same board with cell 5 = 0. Required: empty_count = 1, solved = 0, mismatch = 0, conflict = 0.
- Wrong value: cell 0 = 2 (real 1), fill bit 0 = 0. Required: mismatch = 16'h0001, conflict = 12'h111 (row0, col0, box0), solved = 0. Repeat with fill bit 0 = 1: mismatch = 0, conflict still 12'h111.
- Illegal value: cell 15 = 7. Required: mismatch bit 15 = 1, no extra conflict bits, solved = 0.
- Start while busy, then reset mid-scan: second start at T0+5 is ignored (done only at T0+30). Then start again, assert reset at T0+10, release, and pulse start. Required: no stray done pulse, and the fresh scan completes in 30 cycles with correct results.
